// File: rtl/usb_sess.sv
// User-side USB session controller: command valid/ready to fs_send/fd_send handshake,
// fs_read/fd_read acknowledge with a status pulse, and a ring of RAM slots for received data.
module usb_sess #(
    parameter logic [11:0] SLOT_SIZE = 12'd512,
    parameter int          SLOT_NUM  = 8,
    parameter logic [3:0]  BT_DATA   = 4'h2,
    parameter logic [15:0] TIMEOUT   = 16'd50000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    input  logic [3:0]  cmd_btype,
    input  logic [31:0] cmd_data,
    output logic        cmd_ready,
    output logic        tx_err,
    output logic        fs_send,
    output logic [3:0]  send_btype,
    output logic [31:0] cache_cmd,
    input  logic        fd_send,
    input  logic        fs_read,
    input  logic [3:0]  read_btype,
    input  logic [31:0] cache_stat,
    output logic        fd_read,
    output logic [11:0] read_ram_init,
    output logic        stat_valid,
    output logic [3:0]  stat_btype,
    output logic [31:0] stat_data,
    output logic        slot_rdy,
    output logic [11:0] slot_base,
    input  logic        slot_free,
    output logic        ovf,
    input  logic        ovf_clr
);

    localparam int PW = $clog2(SLOT_NUM);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] SLOT_FULL = CW'(SLOT_NUM);

    typedef enum logic [1:0] {T_IDLE, T_SEND, T_WAIT} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_LATCH, R_ACK} rx_state_t;

    tx_state_t     r_tx_state, w_tx_next;
    rx_state_t     r_rx_state, w_rx_next;
    logic [15:0]   r_tx_cnt;
    logic [3:0]    r_send_btype;
    logic [31:0]   r_cache_cmd;
    logic          w_tx_acc, w_tx_to;
    logic          r_stat_valid;
    logic [3:0]    r_stat_btype;
    logic [31:0]   r_stat_data;
    logic [PW-1:0] r_slot_wp, r_slot_rp;
    logic [CW-1:0] r_slot_cnt;
    logic          r_ovf;
    logic          w_latch, w_is_data, w_adv, w_ovf_set, w_free;

    // TX: command acceptance, fs_send hold, timeout on missing fd_send
    always_comb begin
        w_tx_next = r_tx_state;
        w_tx_acc  = 1'b0;
        w_tx_to   = 1'b0;
        case (r_tx_state)
            T_IDLE: if (cmd_valid) begin
                w_tx_acc  = 1'b1;
                w_tx_next = T_SEND;
            end
            T_SEND: begin
                if (fd_send) begin
                    w_tx_next = T_WAIT;
                end else if (r_tx_cnt == TIMEOUT - 16'd1) begin
                    w_tx_to   = 1'b1;
                    w_tx_next = T_WAIT;
                end
            end
            T_WAIT:  if (!fd_send) w_tx_next = T_IDLE;
            default: w_tx_next = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state   <= T_IDLE;
            r_tx_cnt     <= 16'd0;
            r_send_btype <= 4'd0;
            r_cache_cmd  <= 32'd0;
        end else begin
            r_tx_state <= w_tx_next;
            if (w_tx_acc) begin
                r_tx_cnt     <= 16'd0;
                r_send_btype <= cmd_btype;
                r_cache_cmd  <= cmd_data;
            end else if (r_tx_state == T_SEND) begin
                r_tx_cnt <= r_tx_cnt + 16'd1;
            end
        end
    end

    // RX: one latch cycle, then hold fd_read until fs_read drops
    always_comb begin
        w_rx_next = r_rx_state;
        case (r_rx_state)
            R_IDLE:  if (fs_read) w_rx_next = R_LATCH;
            R_LATCH: w_rx_next = R_ACK;
            R_ACK:   if (!fs_read) w_rx_next = R_IDLE;
            default: w_rx_next = R_IDLE;
        endcase
    end

    assign w_latch   = (r_rx_state == R_LATCH);
    assign w_is_data = w_latch && (read_btype == BT_DATA);
    assign w_adv     = w_is_data && (r_slot_cnt != SLOT_FULL);
    assign w_ovf_set = w_is_data && (r_slot_cnt == SLOT_FULL);
    assign w_free    = slot_free && (r_slot_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state   <= R_IDLE;
            r_stat_valid <= 1'b0;
            r_stat_btype <= 4'd0;
            r_stat_data  <= 32'd0;
        end else begin
            r_rx_state   <= w_rx_next;
            r_stat_valid <= w_latch;
            if (w_latch) begin
                r_stat_btype <= read_btype;
                r_stat_data  <= cache_stat;
            end
        end
    end

    // Slot ring: pointers wrap naturally since SLOT_NUM is a power of two
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_slot_wp  <= '0;
            r_slot_rp  <= '0;
            r_slot_cnt <= '0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_adv)  r_slot_wp <= r_slot_wp + PW'(1);
            if (w_free) r_slot_rp <= r_slot_rp + PW'(1);
            case ({w_adv, w_free})
                2'b10:   r_slot_cnt <= r_slot_cnt + CW'(1);
                2'b01:   r_slot_cnt <= r_slot_cnt - CW'(1);
                default: r_slot_cnt <= r_slot_cnt;
            endcase
            if (w_ovf_set)    r_ovf <= 1'b1;
            else if (ovf_clr) r_ovf <= 1'b0;
        end
    end

    assign cmd_ready     = (r_tx_state == T_IDLE);
    assign fs_send       = (r_tx_state == T_SEND);
    assign tx_err        = w_tx_to;
    assign send_btype    = r_send_btype;
    assign cache_cmd     = r_cache_cmd;
    assign fd_read       = (r_rx_state == R_ACK);
    assign stat_valid    = r_stat_valid;
    assign stat_btype    = r_stat_btype;
    assign stat_data     = r_stat_data;
    assign read_ram_init = 12'(r_slot_wp) * SLOT_SIZE;
    assign slot_base     = 12'(r_slot_rp) * SLOT_SIZE;
    assign slot_rdy      = (r_slot_cnt != '0);
    assign ovf           = r_ovf;

endmodule

// File: tb/tb_usb_sess.sv
// Scoreboard bench for usb_sess: directed stimulus pushes expected status/command records,
// a negedge monitor pops and compares them when stat_valid or a rising fs_send appears.
module tb_usb_sess;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_btype = 4'd0;
    logic [31:0] cmd_data = 32'd0;
    logic        cmd_ready, tx_err, fs_send, fd_read, stat_valid, slot_rdy, ovf;
    logic [3:0]  send_btype, stat_btype;
    logic [31:0] cache_cmd, stat_data;
    logic [11:0] read_ram_init, slot_base;
    logic        fd_send = 1'b0;
    logic        fs_read = 1'b0;
    logic [3:0]  read_btype = 4'd0;
    logic [31:0] cache_stat = 32'd0;
    logic        slot_free = 1'b0;
    logic        ovf_clr = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0]  bt;
        logic [31:0] data;
        logic [11:0] init;
        logic [11:0] base;
        logic        rdy;
        logic        ovf;
    } rx_exp_t;

    typedef struct {
        logic [3:0]  bt;
        logic [31:0] data;
    } tx_exp_t;

    rx_exp_t rx_q[$];
    tx_exp_t tx_q[$];
    rx_exp_t m_rx;
    tx_exp_t m_tx;
    logic    m_prev_fs = 1'b0;

    usb_sess #(
        .SLOT_SIZE(12'd512),
        .SLOT_NUM (8),
        .BT_DATA  (4'h2),
        .TIMEOUT  (16'd16)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_btype    (cmd_btype),
        .cmd_data     (cmd_data),
        .cmd_ready    (cmd_ready),
        .tx_err       (tx_err),
        .fs_send      (fs_send),
        .send_btype   (send_btype),
        .cache_cmd    (cache_cmd),
        .fd_send      (fd_send),
        .fs_read      (fs_read),
        .read_btype   (read_btype),
        .cache_stat   (cache_stat),
        .fd_read      (fd_read),
        .read_ram_init(read_ram_init),
        .stat_valid   (stat_valid),
        .stat_btype   (stat_btype),
        .stat_data    (stat_data),
        .slot_rdy     (slot_rdy),
        .slot_base    (slot_base),
        .slot_free    (slot_free),
        .ovf          (ovf),
        .ovf_clr      (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_tx(input logic [3:0] bt, input logic [31:0] d);
        tx_exp_t e;
        e.bt = bt;
        e.data = d;
        tx_q.push_back(e);
        cmd_valid = 1'b1;
        cmd_btype = bt;
        cmd_data  = d;
    endtask

    task automatic rx_pkt(input logic [3:0] bt, input logic [31:0] d, input logic clr,
                          input logic fr, input logic [11:0] old_init, input logic [11:0] new_init,
                          input logic [11:0] base, input logic rdy, input logic ov);
        rx_exp_t e;
        e.bt = bt; e.data = d; e.init = new_init; e.base = base; e.rdy = rdy; e.ovf = ov;
        rx_q.push_back(e);
        fs_read = 1'b1; read_btype = bt; cache_stat = d;
        tick();
        chk("fd_read_latch", fd_read, 0);
        chk("ram_init_latch", read_ram_init, old_init);
        ovf_clr = clr; slot_free = fr;
        tick();
        ovf_clr = 1'b0; slot_free = 1'b0;
        chk("fd_read_ack", fd_read, 1);
        fs_read = 1'b0; read_btype = 4'd0; cache_stat = 32'd0;
        tick();
        chk("fd_read_drop", fd_read, 0);
    endtask

    task automatic free_slot();
        slot_free = 1'b1;
        tick();
        slot_free = 1'b0;
    endtask

    // Monitor: compares DUT presentations against the scoreboard queues
    always @(negedge clk) begin
        if (!rst) begin
            m_prev_fs = 1'b0;
        end else begin
            if (stat_valid) begin
                if (rx_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rx_unexpected: stat_valid btype=%0h data=%0h, none expected",
                             stat_btype, stat_data);
                end else begin
                    m_rx = rx_q.pop_front();
                    chk("stat_btype", stat_btype, m_rx.bt);
                    chk("stat_data", stat_data, m_rx.data);
                    chk("read_ram_init", read_ram_init, m_rx.init);
                    chk("slot_base", slot_base, m_rx.base);
                    chk("slot_rdy", slot_rdy, m_rx.rdy);
                    chk("ovf", ovf, m_rx.ovf);
                end
            end
            if (fs_send && !m_prev_fs) begin
                if (tx_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL tx_unexpected: fs_send rose btype=%0h cmd=%0h, none expected",
                             send_btype, cache_cmd);
                end else begin
                    m_tx = tx_q.pop_front();
                    chk("send_btype", send_btype, m_tx.bt);
                    chk("cache_cmd", cache_cmd, m_tx.data);
                end
            end
            m_prev_fs = fs_send;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tick();
        tick();
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_fs_send", fs_send, 0);
        chk("rst_fd_read", fd_read, 0);
        chk("rst_ram_init", read_ram_init, 0);
        chk("rst_slot_rdy", slot_rdy, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_tx_err", tx_err, 0);
        rst = 1'b1;
        tick();

        // Normal command with fd_send after 3 cycles
        push_tx(4'h1, 32'hA5A5_0001);
        tick();
        cmd_valid = 1'b0;
        chk("t1_fs_send_up", fs_send, 1);
        chk("t1_cmd_ready_low", cmd_ready, 0);
        tick();
        tick();
        chk("t1_fs_send_hold", fs_send, 1);
        fd_send = 1'b1;
        tick();
        chk("t1_fs_send_drop", fs_send, 0);
        chk("t1_cmd_ready_wait", cmd_ready, 0);
        chk("t1_no_tx_err", tx_err, 0);
        fd_send = 1'b0;
        tick();
        chk("t1_cmd_ready_back", cmd_ready, 1);

        // Timeout with TIMEOUT=16
        push_tx(4'h3, 32'hDEAD_0002);
        tick();
        cmd_valid = 1'b0;
        repeat (14) tick();
        chk("t2_no_err_c15", tx_err, 0);
        chk("t2_fs_send_c15", fs_send, 1);
        tick();
        chk("t2_tx_err_c16", tx_err, 1);
        tick();
        chk("t2_tx_err_gone", tx_err, 0);
        chk("t2_fs_send_low", fs_send, 0);
        tick();
        chk("t2_cmd_ready", cmd_ready, 1);

        // First data packet, then a non-data packet
        rx_pkt(4'h2, 32'h0000_1234, 1'b0, 1'b0, 12'd0, 12'd512, 12'd0, 1'b1, 1'b0);
        rx_pkt(4'h5, 32'h0000_0055, 1'b0, 1'b0, 12'd512, 12'd512, 12'd0, 1'b1, 1'b0);

        // Fill all 8 slots, then overflow
        for (int k = 2; k <= 8; k++)
            rx_pkt(4'h2, 32'h100 + k, 1'b0, 1'b0, 12'(((k - 1) % 8) * 512),
                   12'((k % 8) * 512), 12'd0, 1'b1, 1'b0);
        rx_pkt(4'h2, 32'h109, 1'b0, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared", ovf, 0);
        rx_pkt(4'h2, 32'h10A, 1'b1, 1'b0, 12'd0, 12'd0, 12'd0, 1'b1, 1'b1);
        chk("ovf_clr_loses", ovf, 1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("ovf_cleared2", ovf, 0);

        // Release 5 slots -> cnt 3, then advance and free together
        repeat (5) free_slot();
        chk("t5_base_rp5", slot_base, 12'd2560);
        chk("t5_rdy", slot_rdy, 1);
        rx_pkt(4'h2, 32'h500, 1'b0, 1'b1, 12'd0, 12'd512, 12'd3072, 1'b1, 1'b0);
        free_slot();
        free_slot();
        chk("t5_rdy_cnt1", slot_rdy, 1);
        chk("t5_base_rp0", slot_base, 12'd0);
        free_slot();
        chk("t5_rdy_cnt0", slot_rdy, 0);
        chk("t5_base_rp1", slot_base, 12'd512);
        free_slot();
        chk("t5_free_ignored_base", slot_base, 12'd512);
        chk("t5_free_ignored_rdy", slot_rdy, 0);

        // Reset in the middle of both handshakes
        push_tx(4'h9, 32'hCAFE_0006);
        fs_read = 1'b1; read_btype = 4'h7; cache_stat = 32'h66;
        tick();
        cmd_valid = 1'b0;
        tick();
        chk("t6_fs_send_pre", fs_send, 1);
        chk("t6_fd_read_pre", fd_read, 1);
        #2;
        rst = 1'b0;
        #1;
        chk("t6_fs_send_async", fs_send, 0);
        chk("t6_fd_read_async", fd_read, 0);
        fs_read = 1'b0; read_btype = 4'd0; cache_stat = 32'd0;
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
        chk("t6_cmd_ready", cmd_ready, 1);
        chk("t6_slot_rdy", slot_rdy, 0);
        chk("t6_ram_init", read_ram_init, 0);
        chk("t6_stat_valid", stat_valid, 0);
        tick();
        tick();

        chk("rx_q_drained", rx_q.size(), 0);
        chk("tx_q_drained", tx_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
